// File: rtl/instruction_prefetch_pkg.sv
// Shared LC-3b fetch types: machine word, fetch FSM encoding and the default
// prefetch queue depth.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  localparam int FETCH_QUEUE_DEPTH = 4;

  // Byte-addressed 16-bit instructions
  localparam int FETCH_STEP = 2;

endpackage

// File: rtl/instruction_prefetch_if.sv
// Fetch-side bundle: instruction memory request/response, redirect from
// execute and the decode-facing queue head.
interface instruction_prefetch_if #(
  parameter int WIDTH = 16
);
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;
  logic             imem_read;
  logic [WIDTH-1:0] imem_address;
  logic             imem_resp;
  logic [WIDTH-1:0] imem_rdata;
  logic             deq;
  logic             inst_valid;
  logic [WIDTH-1:0] inst;
  logic [WIDTH-1:0] inst_pc;
  logic             stall_fetch;

  modport master (
    input  redirect, redirect_pc, imem_resp, imem_rdata, deq,
    output imem_read, imem_address, inst_valid, inst, inst_pc, stall_fetch
  );

  modport slave (
    output redirect, redirect_pc, imem_resp, imem_rdata, deq,
    input  imem_read, imem_address, inst_valid, inst, inst_pc, stall_fetch
  );
endinterface

// File: rtl/instruction_prefetch_fetch_queue.sv
// Synchronous FIFO holding {pc, instruction} pairs; flush clears it in one
// cycle and wins over push/pop.
module fetch_queue
  import lc3b_types::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = FETCH_QUEUE_DEPTH,
  localparam int DW    = 2 * WIDTH,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [PW:0]   count,
  output logic [DW-1:0] head
);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          empty, full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (push && !flush) |-> (!full || do_pop));

endmodule

// File: rtl/instruction_prefetch.sv
// Instruction prefetcher: one outstanding imem read at a time feeding a small
// {pc, inst} queue; redirects flush the queue and discard in-flight data.
module instruction_prefetch
  import lc3b_types::*;
#(
  parameter int               WIDTH    = $bits(lc3b_word),
  parameter int               DEPTH    = FETCH_QUEUE_DEPTH,
  parameter logic [WIDTH-1:0] RESET_PC = 16'h0000
) (
  input logic                   clk,
  input logic                   rst_n,
  instruction_prefetch_if.master bus
);

  localparam int               CW      = $clog2(DEPTH) + 1;
  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(FETCH_STEP);

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] word;
  } entry_t;

  fetch_state_t     state, state_d;
  logic [WIDTH-1:0] fetch_pc, fetch_pc_d;
  logic [WIDTH-1:0] req_addr, req_addr_d;
  logic             armed;
  logic             push, pop, valid, has_room;
  logic [CW-1:0]    count;
  entry_t           push_entry, head_entry;

  assign valid    = (count != '0);
  assign has_room = (count < CW'(DEPTH));
  // Redirect wins over deq: the flushed head must not also be popped
  assign pop      = bus.deq && valid && !bus.redirect;

  // armed holds off the first request for one cycle after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      armed    <= 1'b0;
    end else begin
      state    <= state_d;
      fetch_pc <= fetch_pc_d;
      req_addr <= req_addr_d;
      armed    <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state;
    fetch_pc_d = fetch_pc;
    req_addr_d = req_addr;
    push       = 1'b0;
    if (bus.redirect) fetch_pc_d = bus.redirect_pc;
    unique case (state)
      IDLE: begin
        if (!bus.redirect && armed && has_room) begin
          state_d    = REQ;
          req_addr_d = fetch_pc;
        end
      end
      REQ: begin
        // A redirect while waiting keeps the bus request alive but marks the
        // returning data as stale
        if (bus.redirect) begin
          state_d = bus.imem_resp ? IDLE : DROP;
        end else if (bus.imem_resp) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc + PC_STEP;
          state_d    = IDLE;
        end
      end
      DROP: begin
        if (bus.imem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign push_entry = '{pc: fetch_pc, word: bus.imem_rdata};

  fetch_queue #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .count     (count),
    .head      (head_entry)
  );

  assign bus.imem_read    = (state != IDLE);
  assign bus.imem_address = req_addr;
  assign bus.inst_valid   = valid;
  assign bus.inst         = valid ? head_entry.word : '0;
  assign bus.inst_pc      = valid ? head_entry.pc   : '0;
  assign bus.stall_fetch  = !valid;

  a_addr_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.imem_read && !bus.imem_resp) |=>
      (bus.imem_read && bus.imem_address == $past(bus.imem_address)));

endmodule
